hilo_unit: RTL and testbench



---
 rtl/hilo_pkg.sv | 25 ++
 rtl/hilo_unit_div_step.sv | 23 ++
 rtl/hilo_unit.sv | 147 ++++++++++++++
 tb/tb_hilo_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO register unit.
package hilo_pkg;
    localparam int WIDTH     = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 5;

    typedef enum logic [2:0] {
        NOP     = 3'd0,
        MULT_WR = 3'd1,
        DIV     = 3'd2,
        DIVU    = 3'd3,
        MTHI    = 3'd4,
        MTLO    = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction
endpackage

// File: rtl/hilo_unit_div_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step
    import hilo_pkg::*;
(
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    // One extra bit so a remainder >= 2^31 cannot overflow when shifted.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_i};
        ge      = shifted >= {1'b0, divisor_i};
        rem_o   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], ge};
    end
endmodule

// File: rtl/hilo_unit.sv
// HI/LO register file with single-cycle writes and a fixed 34-edge iterative divider.
module hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   inpA,
    input  logic [WIDTH-1:0]   inpB,
    input  logic [2*WIDTH-1:0] inpProd,
    output logic               busy,
    output logic               done,
    output logic               divByZero,
    output logic [WIDTH-1:0]   outHi,
    output logic [WIDTH-1:0]   outLo
);
    import hilo_pkg::*;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             negq_q, negq_d, negr_q, negr_d;
    logic             done_q, done_d, dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem, step_quo;
    op_e              op_s;
    logic             accept, is_signed;

    div_step u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign op_s      = op_e'(op);
    assign accept    = start && (state_q == IDLE) && (op_s != NOP);
    assign is_signed = (op_s == DIV);

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dbz_d = 1'b0;
                    case (op_s)
                        MULT_WR: begin
                            hi_d   = inpProd[2*WIDTH-1:WIDTH];
                            lo_d   = inpProd[WIDTH-1:0];
                            done_d = 1'b1;
                        end
                        MTHI: begin
                            hi_d   = inpA;
                            done_d = 1'b1;
                        end
                        MTLO: begin
                            lo_d   = inpA;
                            done_d = 1'b1;
                        end
                        DIV, DIVU: begin
                            if (inpB == '0) begin
                                hi_d   = inpA;
                                lo_d   = '1;
                                dbz_d  = 1'b1;
                                done_d = 1'b1;
                            end else begin
                                // Divide magnitudes; signs are restored in FIX.
                                rem_d   = '0;
                                quo_d   = cond_neg(inpA, is_signed && inpA[WIDTH-1]);
                                dvs_d   = cond_neg(inpB, is_signed && inpB[WIDTH-1]);
                                negq_d  = is_signed && (inpA[WIDTH-1] ^ inpB[WIDTH-1]);
                                negr_d  = is_signed && inpA[WIDTH-1];
                                cnt_d   = '0;
                                state_d = RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = cond_neg(quo_q, negq_q);
                hi_d    = cond_neg(rem_q, negr_q);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign divByZero = dbz_q;
    assign outHi     = hi_q;
    assign outLo     = lo_q;
endmodule

// File: tb/tb_hilo_unit.sv
// Randomized scoreboard bench for hilo_unit against an arithmetic reference model.
module tb_hilo_unit;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] inpA = '0, inpB = '0;
    logic [63:0] inpProd = '0;
    logic        busy, done, divByZero;
    logic [31:0] outHi, outLo;

    hilo_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .start     (start),
        .op        (op),
        .inpA      (inpA),
        .inpB      (inpB),
        .inpProd   (inpProd),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero),
        .outHi     (outHi),
        .outLo     (outLo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    int          checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every done pulse must match the oldest outstanding expected write.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rstN && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done: done=1 with no write outstanding at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("hi", outHi, e.hi);
                chk("lo", outLo, e.lo);
                chk("divByZero", divByZero, e.dbz);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    // Called at posedge+#1; the request is accepted on the next edge (E0).
    task automatic issue(input op_e o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] p, input int ignore_at = -1, input int abort_at = -1);
        longint      sa, sb;
        logic [63:0] ua, ub;
        exp_t        e;
        bit          long_div;
        int          n;
        start    = 1'b1;
        op       = o;
        inpA     = a;
        inpB     = b;
        inpProd  = p;
        long_div = (o == DIV || o == DIVU) && (b != 0);
        e.dbz    = 1'b0;
        case (o)
            MULT_WR: begin m_hi = p[63:32]; m_lo = p[31:0]; end
            MTHI:    m_hi = a;
            MTLO:    m_lo = a;
            DIV, DIVU: begin
                if (b == 0) begin
                    m_hi  = a;
                    m_lo  = 32'hFFFF_FFFF;
                    e.dbz = 1'b1;
                end else if (o == DIV) begin
                    sa   = longint'($signed(a));
                    sb   = longint'($signed(b));
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end else begin
                    ua   = {32'b0, a};
                    ub   = {32'b0, b};
                    m_lo = 32'(ua / ub);
                    m_hi = 32'(ua % ub);
                end
            end
            default: ;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        if (o != NOP) exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (long_div) begin
            chk("busy_after_accept", busy, 1);
            n = 0;
            while (busy && n < 40) begin
                if (n == abort_at) begin
                    #2 rstN = 1'b0;
                    #1;
                    chk("abort_hi", outHi, 0);
                    chk("abort_lo", outLo, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_done", done, 0);
                    exp_q.delete();
                    m_hi = '0;
                    m_lo = '0;
                    #1 rstN = 1'b1;
                    return;
                end
                if (n == ignore_at) begin
                    start = 1'b1;
                    op    = MTHI;
                    inpA  = 32'hDEAD_BEEF;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                #1;
                n++;
            end
            // E0 is the accept edge; the result lands on E33, the 34th edge.
            chk("div_latency_edges", 64'(n), 33);
        end else if (o == DIV || o == DIVU) begin
            chk("dbz_busy", busy, 0);
        end
    endtask

    initial begin : timeout
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        op_e         ops[6];
        logic [31:0] a, b;
        ops = '{NOP, MULT_WR, DIV, DIVU, MTHI, MTLO};
        #1;
        chk("reset_hi", outHi, 0);
        chk("reset_lo", outLo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dbz", divByZero, 0);
        #11 rstN = 1'b1;

        issue(DIVU, 32'd100, 32'd7, '0);
        issue(DIV, 32'hFFFF_FFF9, 32'd2, '0);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, '0);
        issue(DIV, 32'd5, 32'd0, '0);
        issue(MTLO, 32'h1234_5678, '0, '0);
        issue(MULT_WR, '0, '0, 64'h0000_0001_FFFF_FFFE);
        issue(MTHI, 32'hA5A5_A5A5, '0, '0);
        issue(DIVU, 32'd100, 32'd7, '0, 5);
        issue(DIVU, 32'd1234, 32'd5, '0, -1, 10);
        issue(DIVU, 32'd9, 32'd3, '0);

        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            issue(ops[$urandom_range(0, 5)], a, b, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
